// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port between NUM_REQ writeback
//   sources. A round-robin arbiter issues one combinational grant per cycle
//   through valid/ready handshakes. The winning write is registered onto the
//   regfile port one cycle later, and writes to r0 are squashed. A saturating
//   counter records cycles in which two or more sources competed.
//
// Ports
//   clock            : system clock, all state on rising edge
//   ctrl_reset       : asynchronous active-low reset
//   wb_stall         : blocks all grants this cycle
//   req_valid        : per-requester write pending
//   req_reg          : per-requester destination index, slice i = [i*ADDR_W +: ADDR_W]
//   req_data         : per-requester write data, slice i = [i*DATA_W +: DATA_W]
//   req_ready        : one-hot grant (combinational)
//   ctrl_writeEnable : registered regfile write enable
//   ctrl_writeReg    : registered regfile write index
//   data_writeReg    : registered regfile write data
//   grant_id         : requester whose write is on the port (zero-extended)
//   contention_count : saturating count of contended, unstalled cycles
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clock,
  input  logic                      ctrl_reset,
  input  logic                      wb_stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      ctrl_writeEnable,
  output logic [ADDR_W-1:0]         ctrl_writeReg,
  output logic [DATA_W-1:0]         data_writeReg,
  output logic [2:0]                grant_id,
  output logic [CNT_W-1:0]          contention_count
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        gid_q, gid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              grant_hit;
  logic [IDX_W-1:0]  grant_idx;
  logic              take;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic [IDX_W:0]    vcount;
  logic              contend;

  // Search starts one past the last winner so the previous winner has the
  // lowest priority; it only wins again when it is the sole valid source.
  always_comb begin : grant_search
    int unsigned cand;
    cand      = 0;
    grant_hit = 1'b0;
    grant_idx = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = (32'(last_grant_q) + off) % NUM_REQ;
      if (!grant_hit && req_valid[IDX_W'(cand)]) begin
        grant_hit = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
  end

  // Grants are gated by stall and by reset so ready never shows while the
  // output register cannot accept the write.
  assign take = grant_hit && !wb_stall && ctrl_reset;

  always_comb begin
    req_ready = '0;
    sel_reg   = '0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (take && (grant_idx == IDX_W'(i))) begin
        req_ready[i] = 1'b1;
        sel_reg      = req_reg[i*ADDR_W +: ADDR_W];
        sel_data     = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    vcount = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      vcount = vcount + (IDX_W+1)'(req_valid[i]);
    end
  end

  assign contend = !wb_stall && (vcount >= (IDX_W+1)'(2));

  always_comb begin
    last_grant_d = last_grant_q;
    wreg_d       = wreg_q;
    wdata_d      = wdata_q;
    gid_d        = gid_q;
    we_d         = 1'b0;
    cnt_d        = cnt_q;
    if (take) begin
      last_grant_d = grant_idx;
      wreg_d       = sel_reg;
      wdata_d      = sel_data;
      gid_d        = 3'(grant_idx);
      // r0 is hardwired: the handshake completes but no write is issued.
      we_d         = (sel_reg != '0);
    end
    if (contend && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      last_grant_q <= LAST_RST;
      we_q         <= 1'b0;
      wreg_q       <= '0;
      wdata_q      <= '0;
      gid_q        <= '0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      wreg_q       <= wreg_d;
      wdata_q      <= wdata_d;
      gid_q        <= gid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;
  assign grant_id         = gid_q;
  assign contention_count = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Directed bench for regfile_wb_arbiter: a default 3-requester instance
//   and a 2-requester instance with a 4-bit contention counter.
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b0;
  logic        wb_stall = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [14:0] req_reg = '0;
  logic [95:0] req_data = '0;
  logic [2:0]  req_ready;
  logic        we;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic [2:0]  gid;
  logic [15:0] cnt;

  logic [1:0]  b_valid = '0;
  logic [9:0]  b_reg = '0;
  logic [63:0] b_data = '0;
  logic [1:0]  b_ready;
  logic        b_we;
  logic [4:0]  b_wreg;
  logic [31:0] b_wdata;
  logic [2:0]  b_gid;
  logic [3:0]  b_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  regfile_wb_arbiter dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .wb_stall(wb_stall),
    .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data),
    .req_ready(req_ready), .ctrl_writeEnable(we), .ctrl_writeReg(wreg),
    .data_writeReg(wdata), .grant_id(gid), .contention_count(cnt)
  );

  regfile_wb_arbiter #(.NUM_REQ(2), .DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut_sat (
    .clock(clock), .ctrl_reset(ctrl_reset), .wb_stall(1'b0),
    .req_valid(b_valid), .req_reg(b_reg), .req_data(b_data),
    .req_ready(b_ready), .ctrl_writeEnable(b_we), .ctrl_writeReg(b_wreg),
    .data_writeReg(b_wdata), .grant_id(b_gid), .contention_count(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Requester-side protocol: a pending request may not be withdrawn.
  logic [2:0] pend = '0;
  always @(negedge clock) begin
    if (!ctrl_reset) begin
      pend = '0;
    end else begin
      assert ((pend & ~req_valid) == 3'b000) else begin
        bad++;
        $error("FAIL valid_drop: observed=%0b expected=000", pend & ~req_valid);
      end
      pend = req_valid & ~req_ready;
    end
  end

  initial begin
    // Reset state, with requests present to show ready stays low.
    req_valid = 3'b111;
    #2;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_we",    32'(we),        32'h0);
    chk("rst_wreg",  32'(wreg),      32'h0);
    chk("rst_wdata", wdata,          32'h0);
    chk("rst_gid",   32'(gid),       32'h0);
    chk("rst_cnt",   32'(cnt),       32'h0);
    chk("rst_bcnt",  32'(b_cnt),     32'h0);
    tick();

    // Single request from 0 after reset.
    ctrl_reset = 1'b1;
    req_valid  = 3'b001;
    req_reg[0 +: 5]   = 5'd5;
    req_data[0 +: 32] = 32'hDEADBEEF;
    #1 chk("t1_ready", 32'(req_ready), 32'h1);
    tick();
    chk("t1_we",    32'(we),   32'h1);
    chk("t1_wreg",  32'(wreg), 32'h5);
    chk("t1_wdata", wdata,     32'hDEADBEEF);
    chk("t1_gid",   32'(gid),  32'h0);

    // Sole request from 2 moves the pointer to 2.
    req_valid = 3'b100;
    req_reg[10 +: 5]   = 5'd7;
    req_data[64 +: 32] = 32'h77;
    #1 chk("p_ready", 32'(req_ready), 32'h4);
    tick();
    chk("p_we",    32'(we),   32'h1);
    chk("p_wreg",  32'(wreg), 32'h7);
    chk("p_wdata", wdata,     32'h77);
    chk("p_gid",   32'(gid),  32'h2);
    chk("p_cnt",   32'(cnt),  32'h0);

    // All three valid: rotation 0,1,2,0,1,2.
    req_valid = 3'b111;
    for (int i = 0; i < 3; i++) begin
      req_reg[i*5 +: 5]   = 5'(i + 1);
      req_data[i*32 +: 32] = 32'(i + 1) << 8;
    end
    for (int k = 0; k < 6; k++) begin
      #1 chk("t2_ready", 32'(req_ready), 32'(1 << (k % 3)));
      tick();
      chk("t2_we",    32'(we),   32'h1);
      chk("t2_gid",   32'(gid),  32'(k % 3));
      chk("t2_wreg",  32'(wreg), 32'((k % 3) + 1));
      chk("t2_wdata", wdata,     32'((k % 3) + 1) << 8);
    end
    chk("t2_cnt", 32'(cnt), 32'd6);

    // Drain the two still-pending requesters.
    req_valid = 3'b011;
    #1 chk("d_ready0", 32'(req_ready), 32'h1);
    tick();
    chk("d_gid0", 32'(gid), 32'h0);
    chk("d_cnt0", 32'(cnt), 32'd7);
    req_valid = 3'b010;
    #1 chk("d_ready1", 32'(req_ready), 32'h2);
    tick();
    chk("d_gid1", 32'(gid), 32'h1);
    chk("d_cnt1", 32'(cnt), 32'd7);

    // r0 write from requester 1 is squashed but still handshakes.
    req_reg[5 +: 5]   = 5'd0;
    req_data[32 +: 32] = 32'h1234;
    #1 chk("t3_ready", 32'(req_ready), 32'h2);
    tick();
    chk("t3_we",    32'(we),   32'h0);
    chk("t3_wreg",  32'(wreg), 32'h0);
    chk("t3_wdata", wdata,     32'h1234);
    chk("t3_gid",   32'(gid),  32'h1);
    // Pointer advanced to 1: 2 beats 0.
    req_valid = 3'b101;
    #1 chk("t3_next", 32'(req_ready), 32'h4);
    tick();
    chk("t3n_we",   32'(we),   32'h1);
    chk("t3n_gid",  32'(gid),  32'h2);
    chk("t3n_wreg", 32'(wreg), 32'h3);
    chk("t3n_cnt",  32'(cnt),  32'd8);

    // Stall for 4 cycles with everything valid.
    wb_stall  = 1'b1;
    req_valid = 3'b111;
    req_reg[5 +: 5] = 5'd2;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t4_ready", 32'(req_ready), 32'h0);
      tick();
      chk("t4_we",   32'(we),   32'h0);
      chk("t4_gid",  32'(gid),  32'h2);
      chk("t4_wreg", 32'(wreg), 32'h3);
      chk("t4_cnt",  32'(cnt),  32'd8);
    end
    wb_stall = 1'b0;
    #1 chk("t4_rel_ready", 32'(req_ready), 32'h1);
    tick();
    chk("t4_rel_we",   32'(we),   32'h1);
    chk("t4_rel_gid",  32'(gid),  32'h0);
    chk("t4_rel_wreg", 32'(wreg), 32'h1);
    chk("t4_rel_cnt",  32'(cnt),  32'd9);

    // Asynchronous reset while a write sits in the output register.
    ctrl_reset = 1'b0;
    #1;
    chk("t5_we",    32'(we),        32'h0);
    chk("t5_wreg",  32'(wreg),      32'h0);
    chk("t5_wdata", wdata,          32'h0);
    chk("t5_gid",   32'(gid),       32'h0);
    chk("t5_cnt",   32'(cnt),       32'h0);
    chk("t5_ready", 32'(req_ready), 32'h0);
    tick();
    ctrl_reset = 1'b1;
    req_valid  = 3'b110;
    #1 chk("t5_post_ready", 32'(req_ready), 32'h2);
    tick();
    chk("t5_post_we",   32'(we),   32'h1);
    chk("t5_post_gid",  32'(gid),  32'h1);
    chk("t5_post_wreg", 32'(wreg), 32'h2);
    chk("t5_post_cnt",  32'(cnt),  32'd1);
    req_valid = 3'b100;
    #1 chk("t5_fin_ready", 32'(req_ready), 32'h4);
    tick();
    chk("t5_fin_gid", 32'(gid), 32'h2);
    req_valid = 3'b000;

    // 4-bit counter saturation with two requesters always valid.
    b_valid = 2'b11;
    b_reg   = {5'd5, 5'd4};
    b_data  = {32'hB1, 32'hB0};
    #1 chk("t6_ready", 32'(b_ready), 32'h1);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 0) begin
        chk("t6_we",    32'(b_we),   32'h1);
        chk("t6_wreg",  32'(b_wreg), 32'h4);
        chk("t6_wdata", b_wdata,     32'hB0);
        chk("t6_gid",   32'(b_gid),  32'h0);
      end
      chk("t6_cnt", 32'(b_cnt), (k + 1 > 15) ? 32'd15 : 32'(k + 1));
    end
    b_valid = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg) between NUM_REQ writeback sources, e.g. ALU, load unit, multdiv.
- Uses a round-robin arbiter with per-requester valid/ready handshakes.
- Output is registered, so the regfile sees exactly one write per cycle with clean timing.
- Also squashes r0 writes and keeps a saturating contention counter for performance debug.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
DATA_W, 32, write data width
ADDR_W, 5, register index width
CNT_W, 16, contention counter width

Ports:
clock  input  1  system clock, all state on rising edge
ctrl_reset  input  1  asynchronous, active-low reset
wb_stall  input  1  when 1, no grants are issued this cycle
req_valid  input  NUM_REQ  requester i has a write pending
req_reg  input  NUM_REQ*ADDR_W  destination index; slice i = [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  write data; slice i = [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot grant, combinational
ctrl_writeEnable  output  1  registered regfile write enable
ctrl_writeReg  output  ADDR_W  registered regfile write index
data_writeReg  output  DATA_W  registered regfile write data
grant_id  output  3  index of the requester whose write is currently on the port
contention_count  output  CNT_W  saturating count of cycles with contention

Behaviour:
- Reset (ctrl_reset=0, async):
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, grant_id=0, contention_count=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
  - req_ready=0 while reset is asserted.
- Grant (combinational):
  - If wb_stall=0 and any req_valid=1, grant the first valid index searching last_grant+1, last_grant+2, … modulo NUM_REQ.
  - req_ready is one-hot with that index, otherwise all 0.
  - req_ready never asserts for an index whose req_valid=0.
- Transfer: occurs when req_valid[i] & req_ready[i]. Requesters must hold valid/reg/data stable until the transfer; the arbiter does not buffer.
- Latency: on the edge ending a transfer cycle:
  - ctrl_writeReg <= req_reg[i], data_writeReg <= req_data[i], grant_id <= i, last_grant <= i.
  - ctrl_writeEnable <= 1 unless req_reg[i]==0, in which case it is 0 (r0 squash).
  - The regfile write therefore happens one cycle after the handshake.
  - A squashed r0 transfer still completes the handshake and still advances last_grant.
- Idle cycle (no transfer, including any wb_stall=1 cycle):
  - ctrl_writeEnable <= 0.
  - ctrl_writeReg, data_writeReg and grant_id hold their previous values.
  - last_grant is unchanged.
- Throughput: one transfer per cycle. Back-to-back grants to the same requester are allowed only when it is the sole valid requester.
- Fairness: with all NUM_REQ requesters continuously valid, grants rotate 0,1,2,0,1,2… Worst-case wait for any requester is NUM_REQ-1 cycles of unstalled operation.
- Contention counter:
  - Increments by 1 on each edge where wb_stall=0 and popcount(req_valid)>=2.
  - Saturates at 2^CNT_W-1; it never wraps.
  - Cleared only by reset.
- Simultaneous events:
  - If wb_stall rises in the same cycle a requester becomes valid, there is no grant; the request is served on the first unstalled cycle.
  - Valid dropping without a handshake is a protocol violation; it is flagged by a bench assertion, and the RTL needs no handling for it.
- Reset mid-operation: a write pending in the output register is discarded (ctrl_writeEnable forced to 0 immediately, asynchronously); the pointer returns to its reset value.
- Width rules: grant_id is zero-extended to 3 bits; unused requester slices are ignored.

Test Plan:
1. Reset, then req_valid=3'b001, req_reg0=5, req_data0=32'hDEADBEEF → req_ready=001 in the same cycle; next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=DEADBEEF, grant_id=0.
2. All three valid for 6 cycles with distinct regs 1/2/3 → grant order 0,1,2,0,1,2; one write per cycle; contention_count=6.
3. Requester 1 writes reg 0 with data 32'h1234 → req_ready[1]=1 and the handshake completes; next cycle ctrl_writeEnable=0; the next grant starts search at index 2.
4. wb_stall=1 for 4 cycles with req_valid=111 → req_ready=000, ctrl_writeEnable=0, contention_count unchanged; on stall release the requester after last_grant is granted first.
5. Assert ctrl_reset low asynchronously while ctrl_writeEnable=1 → all outputs 0 without waiting for a clock edge; after release with req_valid=110, requester 1 is granted first.
6. With CNT_W=4 override, hold two requesters valid for 20 cycles → contention_count reaches 15 and stays at 15.
